// File: rtl/onchip_mem_bist_pkg.sv
// Shared types and constants for the on-chip memory BIST initiator.
package onchip_mem_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [31:0] PATTERN_INC = 32'h9E37_79B9;
  localparam int          ERR_W       = 16;

endpackage

// File: rtl/onchip_mem_bist_master_if.sv
// Avalon-MM bus between the BIST initiator and the single-port on-chip memory.
interface onchip_mem_bist_master_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   m_address;
  logic [DATA_W/8-1:0] m_byteenable;
  logic                m_chipselect;
  logic                m_write;
  logic [DATA_W-1:0]   m_writedata;
  logic                m_clken;
  logic [DATA_W-1:0]   m_readdata;

  modport master (
    output m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
    input  m_readdata
  );

  modport slave (
    input  m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
    output m_readdata
  );
endinterface

// File: rtl/onchip_mem_bist_patgen.sv
// Test-pattern accumulator: word(i) = seed + i*INC, built by repeated addition.
module onchip_mem_bist_patgen #(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] INC    = DATA_W'(onchip_mem_bist_pkg::PATTERN_INC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              en,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] word
);
  logic [DATA_W-1:0] word_q, word_d;

  // load and en together yield seed+INC, so the word after the one on the bus is ready.
  always_comb begin
    word_d = load ? seed : word_q;
    if (en) word_d = word_d + INC;
  end

  always_ff @(posedge clk) begin
    if (reset) word_q <= '0;
    else       word_q <= word_d;
  end

  assign word = word_q;
endmodule

// File: rtl/onchip_mem_bist_master.sv
// Power-up memory self-test: write a pattern over a word range, read it back,
// compare, and report pass/fail, error count and first failing address.
module onchip_mem_bist_master #(
  parameter int                ADDR_W       = 13,
  parameter int                DATA_W       = 32,
  parameter int                DEPTH        = 5120,
  parameter int                READ_LATENCY = 1,
  parameter logic [DATA_W-1:0] PATTERN_INC  = DATA_W'(onchip_mem_bist_pkg::PATTERN_INC)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [ADDR_W-1:0]                     base_addr,
  input  logic [ADDR_W:0]                       word_count,
  input  logic [DATA_W-1:0]                     seed,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  pass,
  output logic                                  range_err,
  output logic [onchip_mem_bist_pkg::ERR_W-1:0] err_count,
  output logic [ADDR_W-1:0]                     first_err_addr,
  onchip_mem_bist_master_if.master              mem
);
  import onchip_mem_bist_pkg::*;

  localparam logic [ADDR_W:0]   IDX_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   DRAIN_END = (ADDR_W+1)'(READ_LATENCY-1);
  localparam logic [ADDR_W+1:0] DEPTH_W   = (ADDR_W+2)'(DEPTH);
  localparam logic [ERR_W-1:0]  ERR_ONE   = ERR_W'(1);

  state_e                                  state_q, state_d;
  logic [ADDR_W-1:0]                       base_q, base_d;
  logic [ADDR_W:0]                         n_q, n_d;
  logic [ADDR_W:0]                         idx_q, idx_d;
  logic [DATA_W-1:0]                       seed_q, seed_d;
  logic                                    busy_q, busy_d;
  logic                                    done_q, done_d;
  logic                                    pass_q, pass_d;
  logic                                    range_err_q, range_err_d;
  logic [ERR_W-1:0]                        err_count_q, err_count_d;
  logic [ADDR_W-1:0]                       first_err_addr_q, first_err_addr_d;
  logic [ADDR_W-1:0]                       m_address_q, m_address_d;
  logic                                    m_cs_q, m_cs_d;
  logic                                    m_write_q, m_write_d;
  logic [DATA_W-1:0]                       m_wdata_q, m_wdata_d;
  logic [READ_LATENCY:1]                   vld_pipe_q, vld_pipe_d;
  logic [READ_LATENCY:1][DATA_W-1:0]       exp_pipe_q, exp_pipe_d;
  logic [READ_LATENCY:1][ADDR_W-1:0]       addr_pipe_q, addr_pipe_d;

  logic                                    pat_load, pat_en;
  logic [DATA_W-1:0]                       pat_seed, pat_word;
  logic                                    over_range;

  assign pat_seed   = (state_q == S_IDLE) ? seed : seed_q;
  assign over_range = ({2'b00, base_addr} + {1'b0, word_count}) > DEPTH_W;

  onchip_mem_bist_patgen #(
    .DATA_W (DATA_W),
    .INC    (PATTERN_INC)
  ) u_patgen (
    .clk   (clk),
    .reset (reset),
    .load  (pat_load),
    .en    (pat_en),
    .seed  (pat_seed),
    .word  (pat_word)
  );

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    n_d              = n_q;
    idx_d            = idx_q;
    seed_d           = seed_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    pass_d           = pass_q;
    range_err_d      = range_err_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    m_address_d      = m_address_q;
    m_cs_d           = m_cs_q;
    m_write_d        = m_write_q;
    m_wdata_d        = m_wdata_q;
    pat_load         = 1'b0;
    pat_en           = 1'b0;

    // During reads m_writedata carries the expected word, so it doubles as the pipe input.
    vld_pipe_d[1]  = m_cs_q & ~m_write_q;
    exp_pipe_d[1]  = m_wdata_q;
    addr_pipe_d[1] = m_address_q;
    for (int k = 2; k <= READ_LATENCY; k++) begin
      vld_pipe_d[k]  = vld_pipe_q[k-1];
      exp_pipe_d[k]  = exp_pipe_q[k-1];
      addr_pipe_d[k] = addr_pipe_q[k-1];
    end

    if (vld_pipe_q[READ_LATENCY] && (mem.m_readdata != exp_pipe_q[READ_LATENCY])) begin
      if (err_count_q != '1) err_count_d = err_count_q + ERR_ONE;
      if (err_count_q == '0) first_err_addr_d = addr_pipe_q[READ_LATENCY];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d           = base_addr;
          n_d              = word_count;
          seed_d           = seed;
          err_count_d      = '0;
          first_err_addr_d = '0;
          pass_d           = 1'b0;
          busy_d           = 1'b1;
          if (word_count == '0) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            pass_d      = 1'b1;
            range_err_d = 1'b0;
          end else if (over_range) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            range_err_d = 1'b1;
          end else begin
            state_d     = S_WRITE;
            range_err_d = 1'b0;
            m_cs_d      = 1'b1;
            m_write_d   = 1'b1;
            m_address_d = base_addr;
            m_wdata_d   = seed;
            pat_load    = 1'b1;
            pat_en      = 1'b1;
            idx_d       = IDX_ONE;
          end
        end
      end
      S_WRITE, S_READ: begin
        if (idx_q == n_q) begin
          if (state_q == S_WRITE) begin
            state_d     = S_READ;
            m_write_d   = 1'b0;
            m_address_d = base_q;
            m_wdata_d   = seed_q;
            pat_load    = 1'b1;
            pat_en      = 1'b1;
            idx_d       = IDX_ONE;
          end else begin
            state_d = S_DRAIN;
            m_cs_d  = 1'b0;
            idx_d   = '0;
          end
        end else begin
          m_address_d = base_q + idx_q[ADDR_W-1:0];
          m_wdata_d   = pat_word;
          pat_en      = 1'b1;
          idx_d       = idx_q + IDX_ONE;
        end
      end
      S_DRAIN: begin
        // The last compare lands on this edge, so pass uses the updated count.
        if (idx_q == DRAIN_END) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (err_count_d == '0) && !range_err_q;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      base_q           <= '0;
      n_q              <= '0;
      idx_q            <= '0;
      seed_q           <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      range_err_q      <= 1'b0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      m_address_q      <= '0;
      m_cs_q           <= 1'b0;
      m_write_q        <= 1'b0;
      m_wdata_q        <= '0;
      vld_pipe_q       <= '0;
      exp_pipe_q       <= '0;
      addr_pipe_q      <= '0;
    end else begin
      state_q          <= state_d;
      base_q           <= base_d;
      n_q              <= n_d;
      idx_q            <= idx_d;
      seed_q           <= seed_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      range_err_q      <= range_err_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      m_address_q      <= m_address_d;
      m_cs_q           <= m_cs_d;
      m_write_q        <= m_write_d;
      m_wdata_q        <= m_wdata_d;
      vld_pipe_q       <= vld_pipe_d;
      exp_pipe_q       <= exp_pipe_d;
      addr_pipe_q      <= addr_pipe_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign range_err        = range_err_q;
  assign err_count        = err_count_q;
  assign first_err_addr   = first_err_addr_q;
  assign mem.m_address    = m_address_q;
  assign mem.m_chipselect = m_cs_q;
  assign mem.m_write      = m_write_q;
  assign mem.m_writedata  = m_wdata_q;
  assign mem.m_byteenable = '1;
  assign mem.m_clken      = 1'b1;
endmodule

// File: tb/tb_onchip_mem_bist_master.sv
// Bench for onchip_mem_bist_master: table of directed runs, hand sequences, random runs vs a model.
module tb_onchip_mem_bist_master;
  localparam logic [31:0] INC = 32'h9E3779B9;
  localparam int DEPTH = 5120;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [12:0] base_addr = '0;
  logic [13:0] word_count = '0;
  logic [31:0] seed = '0;
  logic busy, done, pass, range_err;
  logic [15:0] err_count;
  logic [12:0] first_err_addr;

  onchip_mem_bist_master_if #(.ADDR_W(13), .DATA_W(32)) bus();

  onchip_mem_bist_master dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .range_err(range_err), .err_count(err_count), .first_err_addr(first_err_addr),
    .mem(bus)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle read latency, optional stuck bits at one address.
  logic [31:0] mem_arr [0:8191];
  logic [31:0] rd_q = '0;
  bit          flt_on = 1'b0;
  logic [12:0] flt_addr = '0;
  logic [31:0] flt_and = '0, flt_or = '0;

  always @(posedge clk) begin
    if (bus.m_chipselect && bus.m_clken) begin
      if (bus.m_write) mem_arr[bus.m_address] <= bus.m_writedata;
      else if (flt_on && bus.m_address == flt_addr)
        rd_q <= (mem_arr[bus.m_address] & ~flt_and) | flt_or;
      else rd_q <= mem_arr[bus.m_address];
    end
  end
  assign bus.m_readdata = rd_q;

  int n_tests = 0, n_fail = 0;

  typedef struct {
    int done; bit pass; bit rng; int err; int first; int ncs; int maxa;
  } exp_t;
  typedef struct {
    int b; int n; logic [31:0] s; bit flt; int fa; logic [31:0] fand; int glitch; exp_t e;
  } vec_t;
  typedef struct {
    int done_cyc; int ncs; int maxa; int bad_bus; int busy_bad;
  } res_t;

  logic [31:0] wlog [0:3];

  task automatic chk(input string nm, input longint got, input longint want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, got, want);
    end
  endtask

  // Reference: pattern by multiplication, faults applied to the read-back word.
  function automatic exp_t model(input int b, input int n, input logic [31:0] s);
    exp_t e;
    logic [31:0] w, r;
    e = '{default: 0};
    e.rng  = (n != 0) && (b + n > DEPTH);
    e.done = (n == 0 || e.rng) ? 1 : 2 * n + 2;
    e.ncs  = (n == 0 || e.rng) ? 0 : 2 * n;
    e.maxa = (n == 0 || e.rng) ? 0 : b + n - 1;
    if (!e.rng)
      for (int i = 0; i < n; i++) begin
        w = s + 32'(i) * INC;
        r = (flt_on && (b + i) == int'(flt_addr)) ? ((w & ~flt_and) | flt_or) : w;
        if (r != w) begin
          if (e.err == 0) e.first = b + i;
          e.err++;
        end
      end
    e.pass = !e.rng && e.err == 0;
    return e;
  endfunction

  task automatic run_bist(input int b, input int n, input logic [31:0] s, input int glitch,
                          output res_t r);
    int wi, ri;
    logic [31:0] ew;
    r = '{default: 0};
    r.done_cyc = -1;
    wi = 0; ri = 0;
    @(negedge clk);
    start = 1'b1; base_addr = 13'(b); word_count = 14'(n); seed = s;
    for (int cyc = 1; cyc <= 12000; cyc++) begin
      @(negedge clk);
      if (cyc == glitch) begin
        start = 1'b1; base_addr = ~13'(b); word_count = 14'd5; seed = ~s;
      end else start = 1'b0;
      if (!busy) r.busy_bad++;
      if (bus.m_chipselect) begin
        r.ncs++;
        if (int'(bus.m_address) > r.maxa) r.maxa = int'(bus.m_address);
        if (bus.m_write) begin
          ew = s + 32'(wi) * INC;
          if (wi < 4) wlog[wi] = bus.m_writedata;
          if (bus.m_address != 13'(b + wi) || bus.m_writedata != ew || ri != 0) r.bad_bus++;
          wi++;
        end else begin
          if (bus.m_address != 13'(b + ri) || wi != n) r.bad_bus++;
          ri++;
        end
      end
      if (done) begin
        r.done_cyc = cyc;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
    if (busy || done || bus.m_chipselect) r.busy_bad++;
  endtask

  task automatic check_run(input string tag, input res_t r, input exp_t e);
    chk({tag, ".done_cycle"}, r.done_cyc, e.done);
    chk({tag, ".pass"}, pass, e.pass);
    chk({tag, ".range_err"}, range_err, e.rng);
    chk({tag, ".err_count"}, err_count, e.err);
    chk({tag, ".first_err_addr"}, first_err_addr, e.first);
    chk({tag, ".cs_cycles"}, r.ncs, e.ncs);
    chk({tag, ".max_addr"}, r.maxa, e.maxa);
    chk({tag, ".bus_seq_errs"}, r.bad_bus, 0);
    chk({tag, ".busy_errs"}, r.busy_bad, 0);
  endtask

  vec_t tbl [0:6];

  initial begin
    res_t r;
    exp_t e;
    int b, n, g, quiet;
    logic [31:0] s;

    //          base     n     seed          flt fa     fand  gl  done  pass rng err first ncs   maxa
    tbl[0] = '{'h010,    4,    32'h0,        0,  0,     0,    0, '{10,    1, 0, 0, 0,     8,    'h013}};
    tbl[1] = '{'h010,    4,    32'h0,        1,  'h011, 1,    0, '{10,    0, 0, 1, 'h011, 8,    'h013}};
    tbl[2] = '{'h020,    0,    32'h5,        0,  0,     0,    1, '{1,     1, 0, 0, 0,     0,    0}};
    tbl[3] = '{'h13F0,   17,   32'h1,        0,  0,     0,    0, '{1,     0, 1, 0, 0,     0,    0}};
    tbl[4] = '{'h13F0,   16,   32'h12345678, 0,  0,     0,    0, '{34,    1, 0, 0, 0,     32,   'h13FF}};
    tbl[5] = '{'h100,    6,    32'hA5A5A5A5, 0,  0,     0,    3, '{14,    1, 0, 0, 0,     12,   'h105}};
    tbl[6] = '{0,        5120, 32'hFFFFFFFF, 0,  0,     0,    0, '{10242, 1, 0, 0, 0,     10240,'h13FF}};

    repeat (3) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.pass", pass, 0);
    chk("rst.range_err", range_err, 0);
    chk("rst.cs", bus.m_chipselect, 0);
    chk("rst.write", bus.m_write, 0);
    chk("rst.err_count", err_count, 0);
    chk("rst.first_err_addr", first_err_addr, 0);
    chk("rst.address", bus.m_address, 0);
    chk("rst.writedata", bus.m_writedata, 0);
    chk("rst.byteenable", bus.m_byteenable, 4'hF);
    chk("rst.clken", bus.m_clken, 1);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      flt_on = tbl[i].flt; flt_addr = 13'(tbl[i].fa); flt_and = tbl[i].fand; flt_or = '0;
      run_bist(tbl[i].b, tbl[i].n, tbl[i].s, tbl[i].glitch, r);
      check_run($sformatf("row%0d", i), r, tbl[i].e);
      if (i == 0) begin
        chk("basic.w0", wlog[0], 32'h00000000);
        chk("basic.w1", wlog[1], 32'h9E3779B9);
        chk("basic.w2", wlog[2], 32'h3C6EF372);
        chk("basic.w3", wlog[3], 32'hDAA66D2B);
      end
    end

    // Abort: reset during the third read cycle (cycle 11 of an 8-word run).
    flt_on = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = 13'h040; word_count = 14'd8; seed = 32'h0BADF00D;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort.reading", bus.m_chipselect && !bus.m_write, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort.cs", bus.m_chipselect, 0);
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    reset = 1'b0;
    quiet = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy || bus.m_chipselect) quiet++;
    end
    chk("abort.quiet", quiet, 0);
    e = model('h040, 8, 32'h0BADF00D);
    run_bist('h040, 8, 32'h0BADF00D, 0, r);
    check_run("after_abort", r, e);

    for (int i = 0; i < 12; i++) begin
      b = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 3) == 0) b = DEPTH - $urandom_range(1, 40);
      n = $urandom_range(0, 48);
      s = $urandom;
      flt_on   = 1'($urandom_range(0, 1));
      flt_addr = 13'(b + ((n > 0) ? $urandom_range(0, n - 1) : 0));
      flt_and  = 32'(1) << $urandom_range(0, 31);
      flt_or   = ($urandom_range(0, 1) == 1) ? (32'(1) << $urandom_range(0, 31)) : 32'h0;
      e = model(b, n, s);
      g = $urandom_range(1, e.done);
      run_bist(b, n, s, g, r);
      check_run($sformatf("rnd%0d", i), r, e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
